// File: rtl/dmac_req_fifo.sv
// rtl/dmac_req_fifo.sv - elastic request buffer between the DMAC arbiter and the bus-interface stage
// Optional zero-latency empty pass-through enabled by defining DMAC_REQ_FIFO_BYPASS_EN.
module dmac_req_fifo #(
  parameter int DEPTH_LG2 = 2,
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [DATA_SIZE-1:0] s_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DATA_SIZE-1:0] m_data_o,
  output logic [DEPTH_LG2:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int DEPTH = 1 << DEPTH_LG2;
  localparam logic [DEPTH_LG2:0]   C_FULL_CNT = {1'b1, {DEPTH_LG2{1'b0}}};
  localparam logic [DEPTH_LG2:0]   C_CNT_ONE  = 1;
  localparam logic [DEPTH_LG2-1:0] C_PTR_ONE  = 1;

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [DEPTH_LG2-1:0] r_wptr;
  logic [DEPTH_LG2-1:0] r_rptr;
  logic [DEPTH_LG2:0]   r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [DATA_SIZE-1:0] w_head;

  assign w_full  = (r_count == C_FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_head  = w_empty ? '0 : r_mem[r_rptr];
  assign w_pop   = m_ready_i && !w_empty;

`ifdef DMAC_REQ_FIFO_BYPASS_EN
  logic w_bypass;

  // An empty FIFO forwards the incoming beat directly; it is only stored if downstream stalls.
  assign w_bypass  = w_empty && s_valid_i;
  assign w_push    = s_valid_i && !w_full && !(w_bypass && m_ready_i);
  assign m_valid_o = !w_empty || w_bypass;
  assign m_data_o  = w_bypass ? s_data_i : w_head;
`else
  assign w_push    = s_valid_i && !w_full;
  assign m_valid_o = !w_empty;
  assign m_data_o  = w_head;
`endif

  assign s_ready_o = !w_full;
  assign count_o   = r_count;
  assign full_o    = w_full;
  assign empty_o   = w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + C_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + C_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; the empty/valid logic masks stale contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= s_data_i;
  end

endmodule

// File: tb/tb_dmac_req_fifo.sv
// tb/tb_dmac_req_fifo.sv - scoreboard bench for dmac_req_fifo
// Covers the DMAC_REQ_FIFO_BYPASS_EN build when that macro is defined.
module tb_dmac_req_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] s_data_i = '0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [31:0] m_data_o;
  logic [2:0]  count_o;
  logic        full_o;
  logic        empty_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  dmac_req_fifo #(.DEPTH_LG2(2), .DATA_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks outputs mid-cycle against the queue model and retires popped entries.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      begin
        int          sz;
        logic        ev;
        logic [31:0] ed;
        sz = exp_q.size();
        ev = (sz > 0);
        ed = (sz > 0) ? exp_q[0] : 32'h0;
`ifdef DMAC_REQ_FIFO_BYPASS_EN
        if (sz == 0 && s_valid_i && rst_n) begin
          ev = 1'b1;
          ed = s_data_i;
        end
`endif
        chk("m_valid", 64'(m_valid_o), 64'(ev));
        chk("m_data", 64'(m_data_o), 64'(ed));
        chk("count", 64'(count_o), 64'(sz));
        chk("full", 64'(full_o), 64'(sz == DEPTH));
        chk("empty", 64'(empty_o), 64'(sz == 0));
        chk("s_ready", 64'(s_ready_o), 64'(sz < DEPTH));
        if (rst_n && sz > 0 && m_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // Driver: applies one beat per cycle and records accepted pushes in the model.
  task automatic step(input logic v, input logic r, input logic [31:0] d);
    logic acc;
    @(negedge clk);
    s_valid_i = v;
    m_ready_i = r;
    s_data_i  = d;
    acc = rst_n && v && (exp_q.size() < DEPTH);
`ifdef DMAC_REQ_FIFO_BYPASS_EN
    if (exp_q.size() == 0 && r) acc = 1'b0;
`endif
    #3;
    if (acc) exp_q.push_back(d);
  endtask

  initial begin
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'h100 + 32'(i));
    step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'hB0 + 32'(i));
    step(1'b1, 1'b1, 32'hB4);
    step(1'b1, 1'b0, 32'hB5);
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hC0 + 32'(i));
    step(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_m_valid", 64'(m_valid_o), 64'(0));
    chk("rst_count", 64'(count_o), 64'(0));
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_m_data", 64'(m_data_o), 64'(0));
    step(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 32'h55);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0);

    step(1'b1, 1'b1, 32'h77);
    step(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 99) < 50), $urandom);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    chk("final_model_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmac_req_fifo.md
Name: dmac_req_fifo

Overview:
- Elastic buffer directly downstream of the DMAC arbiter.
- Accepts the arbitrated valid/ready/data stream and holds up to 2**DEPTH_LG2 entries. This decouples arbiter grants from back-pressure at the bus-interface stage that drains it.
- Exposes occupancy and full/empty status for the DMAC control FSM.

Parameters:
- DEPTH_LG2, 2, log2 of entry count (depth = 4 by default); legal range 1..6
- DATA_SIZE, 32, width of each entry in bits

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- s_valid_i  input  1  upstream (arbiter) data valid
- s_ready_o  output  1  FIFO can accept an entry this cycle
- s_data_i  input  DATA_SIZE  upstream data
- m_valid_o  output  1  head entry valid toward downstream
- m_ready_i  input  1  downstream accepts head entry
- m_data_o  output  DATA_SIZE  head entry data
- count_o  output  DEPTH_LG2+1  number of stored entries, 0..2**DEPTH_LG2
- full_o  output  1  count_o == 2**DEPTH_LG2
- empty_o  output  1  count_o == 0

Behaviour:
- Reset (async assert, sync-safe deassert):
  - write pointer, read pointer and count go to 0
  - outputs: s_ready_o=1, m_valid_o=0, m_data_o=0, count_o=0, full_o=0, empty_o=1
  - storage array is not reset
- Push: s_valid_i && s_ready_o at the rising edge. s_data_i is written to mem[wptr], wptr increments, count increments.
- Pop: m_valid_o && m_ready_i at the rising edge. rptr increments, count decrements.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- Pointers are DEPTH_LG2 bits wide and wrap modulo depth with no special case. Count is a separate DEPTH_LG2+1-bit register.
- s_ready_o = !full_o. It is derived from registered state only and never depends combinationally on m_ready_i.
- When full with m_ready_i=1, no push is accepted that cycle. The pop frees a slot, so s_ready_o=1 the following cycle.
- m_valid_o = !empty_o.
- m_data_o = mem[rptr] when non-empty, 0 when empty.
- While m_valid_o && !m_ready_i, m_data_o must hold stable until popped (AXI-style stability rule).
- s_valid_i=1 with s_data_i changing while s_ready_o=0: nothing is stored and state is unchanged.
- Latency: an entry pushed into an empty FIFO appears on m_valid_o/m_data_o in the next cycle (1 cycle).
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Reset asserted mid-operation discards all entries immediately. Outputs return to their reset values asynchronously.

Optional Feature:
- Macro DMAC_REQ_FIFO_BYPASS_EN.
- Defined:
  - When empty_o=1 and s_valid_i=1, the FIFO drives m_valid_o=1 and m_data_o=s_data_i combinationally in the same cycle.
  - If m_ready_i=1 in that cycle, the transfer passes through: nothing is written, pointers and count are unchanged.
  - If m_ready_i=0, a normal push occurs.
  - Zero-latency path when empty. count_o, full_o and empty_o still reflect stored entries only.
- Undefined: 1-cycle latency as described in Behaviour; m_valid_o depends only on registered state.

Test Plan:
- Reset with s_valid_i=0 -> s_ready_o=1, m_valid_o=0, m_data_o=0, empty_o=1, count_o=0; hold for 3 cycles with no change.
- Push 0xA0..0xA3 (DEPTH_LG2=2) with m_ready_i=0 -> count_o 1,2,3,4; full_o=1 and s_ready_o=0 after 4th push; 5th s_valid_i with 0xA4 is not accepted; m_data_o=0xA0 held stable throughout.
- From full, m_ready_i=1 for 4 cycles, s_valid_i=0 -> pops in order 0xA0,0xA1,0xA2,0xA3; empty_o=1 and m_valid_o=0 afterwards; s_ready_o returns to 1 the cycle after the first pop.
- Continuous s_valid_i=1 and m_ready_i=1 with incrementing data over 10 cycles -> count_o stays at 1 after the first cycle; output sequence matches input with 1-cycle latency; pointers wrap twice without loss.
- Full FIFO, m_ready_i=1 and s_valid_i=1 in the same cycle -> only the pop occurs, count_o 4->3; the next cycle's push is accepted, count_o returns to 4.
- Push 3 entries, assert rst_n=0 mid-cycle -> immediate m_valid_o=0, count_o=0, empty_o=1. After release, the next push of 0x55 is the only entry popped.
- With DMAC_REQ_FIFO_BYPASS_EN defined, empty FIFO, s_valid_i=1, data 0x77, m_ready_i=1 -> m_valid_o=1 and m_data_o=0x77 in the same cycle; count_o stays 0.
